timer: RTL and testbench
========================

TIMER -- requirements
Module: timer

Interface
REQ-001 Parameters: none; all constants come from def.v.
REQ-002 clk  in  1  system clock, all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high; clock clk.
REQ-004 addr  in  2  word select, byte address [3:2]: 0=CTRL, 1=PRESET, 2=COUNT, 3=unused.
REQ-005 we  in  1  bus write strobe, one word per cycle.
REQ-006 write_data  in  32  bus write data.
REQ-007 read_data  out  32  combinational read of the addressed register.
REQ-008 irq  out  1  interrupt request, wired to one bit of the hw_int vector feeding the coprocessor.

Function
REQ-009 CTRL register bits: [0] EN (enable), [2:1] MODE (0 one-shot, 1 auto-reload, 2/3 treated as 0), [3] IM (interrupt mask); bits [31:4] read 0.
REQ-010 PRESET is 32-bit read/write; COUNT is 32-bit read-only; writes to COUNT and to addr 3 are ignored; reads of addr 3 return 0.
REQ-011 FSM states: IDLE, LOAD, CNT, INT.
REQ-012 IDLE: stays while EN=0; goes to LOAD on the cycle after EN=1 is observed.
REQ-013 LOAD: COUNT <= PRESET; next state CNT.
REQ-014 CNT with EN=0: next state IDLE; COUNT holds.
REQ-015 CNT with EN=1 and COUNT>1: COUNT <= COUNT-1; stays in CNT.
REQ-016 CNT with EN=1 and COUNT<=1: COUNT <= 0; next state INT. PRESET=0 therefore reaches INT after exactly one CNT cycle.
REQ-017 INT with MODE=0: pending <= 1, EN <= 0, next state IDLE.
REQ-018 INT with MODE=1: pending is asserted for that cycle only; next state LOAD (reload).
REQ-019 irq = IM & pending, registered output.
REQ-020 pending (MODE=0) holds until any bus write to CTRL clears it.
REQ-021 Latency: from the CTRL write enabling the timer with PRESET=N>=1, irq rises N+3 cycles after the write edge.
REQ-022 A bus write to CTRL takes priority over the FSM's EN clear in the same cycle.
REQ-023 A bus write of EN=0 in any state forces IDLE on the next cycle; COUNT is frozen.
REQ-024 A PRESET write during CNT does not alter COUNT; it takes effect at the next LOAD.
REQ-025 read_data reflects register values before the current cycle's write; no write-through bypass.

Reset
REQ-026 Reset values: CTRL=0, PRESET=0, COUNT=0, state=IDLE, pending=0, irq=0.
REQ-027 Reset mid-count aborts the count and deasserts irq on the next edge.

Configuration
REQ-028 The macro TIMER_AUTO_RELOAD_EN controls mode 1.
REQ-029 With TIMER_AUTO_RELOAD_EN defined, MODE=1 behaves per REQ-018.
REQ-030 Without TIMER_AUTO_RELOAD_EN, MODE bits are stored and read back, but all modes behave as MODE=0 (one-shot).

Structure
REQ-031 def.v holds: FSM state encodings, register word offsets, CTRL bit positions, mode codes and the irq-to-hw_int bit index.
REQ-032 Single module with no sub-module; register file, FSM and counter stay in timer.

Verification
REQ-033 PRESET=5, CTRL=0x9 (EN, MODE0, IM) -> irq rises 8 cycles after the CTRL write; COUNT reads 0; CTRL reads 0x8; irq holds until CTRL is written with 0x8, then falls next cycle.
REQ-034 PRESET=3, CTRL=0xB (EN, MODE1, IM), TIMER_AUTO_RELOAD_EN defined -> one-cycle irq pulse every 5 cycles; EN stays 1.
REQ-035 The same stimulus as REQ-034 without TIMER_AUTO_RELOAD_EN -> a single irq, after which EN is cleared and irq stays high.
REQ-036 PRESET=100 running, CTRL=0 written when COUNT=40 -> state IDLE, COUNT stays 40, no irq; then CTRL=0x9 -> reload from 100.
REQ-037 PRESET=0, CTRL=0x1 (IM=0) -> COUNT=0, EN clears, irq stays 0 throughout; CTRL reads 0x0.
REQ-038 Reset asserted while COUNT=7 in CNT -> all registers 0, irq=0, state IDLE; writes to COUNT and addr 3 read back 0.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared constants for the bus-mapped timer: state encodings, register offsets, CTRL layout, mode codes.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;
    localparam logic [1:0] ADDR_UNUSED = 2'd3;

    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_IM_BIT   = 3;

    localparam logic [1:0] MODE_ONE_SHOT    = 2'd0;
    localparam logic [1:0] MODE_AUTO_RELOAD = 2'd1;

    // Position of irq within the coprocessor's hw_int vector.
    localparam int IRQ_HW_INT_BIT = 5;

    // Field order mirrors the CTRL bit layout, so the struct casts directly to CTRL[3:0].
    typedef struct packed {
        logic       im;
        logic [1:0] mode;
        logic       en;
    } ctrl_t;

endpackage

// File: rtl/timer.sv
// Bus-mapped down-counter timer with a registered interrupt request.
// Mode 1 (auto-reload) is only honoured when TIMER_AUTO_RELOAD_EN is defined.
module timer
    import timer_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        irq
);

    ctrl_t       ctrl_q, ctrl_d;
    logic [31:0] preset_q;
    logic [31:0] count_q, count_d;
    state_t      state_q, state_d;
    logic        pending_q, pending_d;
    logic        reload_pulse;
    logic        auto_reload;
    logic        ctrl_wr;
    logic        preset_wr;

    assign ctrl_wr   = we && (addr == ADDR_CTRL);
    assign preset_wr = we && (addr == ADDR_PRESET);

`ifdef TIMER_AUTO_RELOAD_EN
    assign auto_reload = (ctrl_q.mode == MODE_AUTO_RELOAD);
`else
    assign auto_reload = 1'b0;
`endif

    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        ctrl_d       = ctrl_q;
        pending_d    = pending_q;
        reload_pulse = 1'b0;

        case (state_q)
            ST_IDLE: if (ctrl_q.en) state_d = ST_LOAD;
            ST_LOAD: begin
                count_d = preset_q;
                state_d = ST_CNT;
            end
            ST_CNT: begin
                if (!ctrl_q.en) begin
                    state_d = ST_IDLE;
                end else if (count_q > 32'd1) begin
                    count_d = count_q - 32'd1;
                end else begin
                    count_d = 32'd0;
                    state_d = ST_INT;
                end
            end
            ST_INT: begin
                if (auto_reload) begin
                    reload_pulse = 1'b1;
                    state_d      = ST_LOAD;
                end else begin
                    pending_d = 1'b1;
                    ctrl_d.en = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A CTRL write overrides whatever the FSM decided for CTRL and the interrupt this cycle.
        if (ctrl_wr) begin
            ctrl_d       = ctrl_t'(write_data[3:0]);
            pending_d    = 1'b0;
            reload_pulse = 1'b0;
            if (!write_data[CTRL_EN_BIT]) begin
                state_d = ST_IDLE;
                count_d = count_q;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q    <= '0;
            preset_q  <= '0;
            count_q   <= '0;
            state_q   <= ST_IDLE;
            pending_q <= 1'b0;
            irq       <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            count_q   <= count_d;
            state_q   <= state_d;
            pending_q <= pending_d;
            if (preset_wr) preset_q <= write_data;
            // Built from next-cycle values so irq rises on the same edge that sets pending.
            irq       <= ctrl_d.im & (pending_d | reload_pulse);
        end
    end

    always_comb begin
        read_data = '0;
        case (addr)
            ADDR_CTRL:   read_data = {28'd0, ctrl_q};
            ADDR_PRESET: read_data = preset_q;
            ADDR_COUNT:  read_data = count_q;
            default:     read_data = '0;
        endcase
    end

endmodule

// File: tb/tb_timer.sv
// Self-checking bench for timer: directed scenarios plus random bus traffic against a reference model.
module tb_timer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  addr = 2'd0;
    logic        we = 1'b0;
    logic [31:0] write_data = 32'd0;
    logic [31:0] read_data;
    logic        irq;

    int errors = 0;
    int checks = 0;

    timer dut (
        .clk        (clk),
        .reset      (reset),
        .addr       (addr),
        .we         (we),
        .write_data (write_data),
        .read_data  (read_data),
        .irq        (irq)
    );

    always #5 clk = ~clk;

`ifdef TIMER_AUTO_RELOAD_EN
    localparam bit AUTO_BUILD = 1'b1;
`else
    localparam bit AUTO_BUILD = 1'b0;
`endif

    // Reference model: phase 0 waiting, 1 loading, 2 counting, 3 expired.
    int          m_phase;
    bit          m_en, m_im, m_pending, m_irq;
    bit   [1:0]  m_mode;
    logic [31:0] m_preset, m_count;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [1:0] a);
        case (a)
            2'd0:    return {28'd0, m_im, m_mode, m_en};
            2'd1:    return m_preset;
            2'd2:    return m_count;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_step(input bit r, input bit w, input logic [1:0] a, input logic [31:0] d);
        int          nphase;
        logic [31:0] ncount;
        bit          nen, npend, pulse, reload_mode;
        if (r) begin
            m_phase = 0; m_en = 0; m_im = 0; m_mode = 0;
            m_pending = 0; m_irq = 0; m_preset = 0; m_count = 0;
            return;
        end
        reload_mode = AUTO_BUILD && (m_mode == 2'd1);
        nphase = m_phase; ncount = m_count; nen = m_en; npend = m_pending; pulse = 0;
        if (m_phase == 0) begin
            if (m_en) nphase = 1;
        end else if (m_phase == 1) begin
            ncount = m_preset; nphase = 2;
        end else if (m_phase == 2) begin
            if (!m_en) nphase = 0;
            else if (m_count > 1) ncount = m_count - 1;
            else begin ncount = 0; nphase = 3; end
        end else begin
            if (reload_mode) begin pulse = 1; nphase = 1; end
            else begin npend = 1; nen = 0; nphase = 0; end
        end
        if (w && a == 2'd0) begin
            nen = d[0]; m_mode = d[2:1]; m_im = d[3];
            npend = 0; pulse = 0;
            if (!d[0]) begin nphase = 0; ncount = m_count; end
        end
        if (w && a == 2'd1) m_preset = d;
        m_phase = nphase; m_count = ncount; m_en = nen; m_pending = npend;
        m_irq = m_im & (npend | pulse);
    endtask

    task automatic tick(input bit r, input bit w, input logic [1:0] a, input logic [31:0] d);
        reset = r; we = w; addr = a; write_data = d;
        @(posedge clk);
        model_step(r, w, a, d);
        @(negedge clk);
        check("irq", {31'd0, irq}, {31'd0, m_irq});
        check("read_data", read_data, m_read(a));
    endtask

    task automatic idle(input logic [1:0] a);
        tick(1'b0, 1'b0, a, 32'd0);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        tick(1'b0, 1'b1, a, d);
    endtask

    task automatic rd_check(input string tag, input logic [1:0] a, input logic [31:0] exp);
        we = 1'b0; addr = a;
        #1;
        check(tag, read_data, exp);
    endtask

    task automatic do_reset();
        tick(1'b1, 1'b0, 2'd0, 32'd0);
        tick(1'b1, 1'b0, 2'd0, 32'd0);
    endtask

    task automatic wait_count(input string tag, input logic [31:0] target);
        bit found = 0;
        for (int k = 0; k < 300 && !found; k++) begin
            idle(2'd2);
            if (read_data == target) found = 1;
        end
        check(tag, {31'd0, found}, 32'd1);
    endtask

    initial begin
        int lat;
        int highs[$];
        logic [1:0]  a;
        logic [31:0] d;
        bit          r, w;

        // Reset state
        do_reset();
        rd_check("rst_ctrl", 2'd0, 32'd0);
        rd_check("rst_preset", 2'd1, 32'd0);
        rd_check("rst_count", 2'd2, 32'd0);
        rd_check("rst_unused", 2'd3, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);

        // One-shot: PRESET=5, CTRL=0x9 -> irq 8 cycles after the write
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h9);
        lat = -1;
        for (int k = 1; k <= 20 && lat < 0; k++) begin
            idle(2'd2);
            if (irq === 1'b1) lat = k;
        end
        check("latency_n5", lat, 32'd8);
        rd_check("count_after_irq", 2'd2, 32'd0);
        rd_check("ctrl_en_cleared", 2'd0, 32'h8);
        idle(2'd0); idle(2'd0);
        check("irq_held", {31'd0, irq}, 32'd1);
        wr(2'd0, 32'h8);
        check("irq_cleared", {31'd0, irq}, 32'd0);

        // Stop mid-count, then restart from PRESET
        do_reset();
        wr(2'd1, 32'd100);
        wr(2'd0, 32'h9);
        wait_count("reach_40", 32'd40);
        wr(2'd0, 32'h0);
        idle(2'd2); idle(2'd2); idle(2'd2);
        rd_check("count_frozen", 2'd2, 32'd40);
        check("no_irq_stopped", {31'd0, irq}, 32'd0);
        wr(2'd0, 32'h9);
        idle(2'd2); idle(2'd2);
        rd_check("reloaded_100", 2'd2, 32'd100);

        // PRESET=0 with IM=0: expires silently, EN clears
        do_reset();
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h1);
        for (int k = 0; k < 8; k++) begin
            idle(2'd0);
            check("irq_masked", {31'd0, irq}, 32'd0);
        end
        rd_check("ctrl_p0", 2'd0, 32'h0);
        rd_check("count_p0", 2'd2, 32'd0);

        // Reset mid-count, then writes to read-only/unused locations
        do_reset();
        wr(2'd1, 32'd20);
        wr(2'd0, 32'h9);
        wait_count("reach_7", 32'd7);
        tick(1'b1, 1'b0, 2'd2, 32'd0);
        idle(2'd2);
        rd_check("rst_mid_ctrl", 2'd0, 32'd0);
        rd_check("rst_mid_preset", 2'd1, 32'd0);
        rd_check("rst_mid_count", 2'd2, 32'd0);
        check("rst_mid_irq", {31'd0, irq}, 32'd0);
        wr(2'd2, 32'h1234);
        wr(2'd3, 32'h55);
        rd_check("count_ro", 2'd2, 32'd0);
        rd_check("unused_ro", 2'd3, 32'd0);

        // PRESET=3, CTRL=0xB: periodic pulses with auto-reload, sticky irq otherwise
        do_reset();
        wr(2'd1, 32'd3);
        wr(2'd0, 32'hB);
        for (int k = 1; k <= 30; k++) begin
            idle(2'd0);
            if (irq === 1'b1) highs.push_back(k);
        end
        check("first_irq_n3", (highs.size() > 0) ? highs[0] : -1, 32'd6);
`ifdef TIMER_AUTO_RELOAD_EN
        check("pulse_count", highs.size(), 32'd5);
        for (int i = 1; i < highs.size(); i++) check("pulse_period", highs[i] - highs[i-1], 32'd5);
        rd_check("ctrl_reload_en", 2'd0, 32'hB);
`else
        check("sticky_count", highs.size(), 32'd25);
        rd_check("ctrl_oneshot_en", 2'd0, 32'hA);
`endif

        // Random bus traffic against the model
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            r = ($urandom_range(0, 299) == 0);
            w = ($urandom_range(0, 11) == 0);
            a = 2'($urandom_range(0, 3));
            d = $urandom;
            if (a == 2'd0) d[0] = ($urandom_range(0, 4) != 0);
            if (a == 2'd1) d = 32'($urandom_range(0, 12));
            tick(r, w, a, d);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
